// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory read arbiter: default widths, the WAIT
// timeout default, the WAIT counter width, the FSM state encoding and a helper
// that turns a TIMEOUT cycle count into the last WAIT count before expiry.
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 200;
    localparam int CNT_W       = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // The counter is 0 in the first WAIT cycle, so the read expires in the
    // cycle where it holds timeout-1. Values beyond the counter range clamp to
    // the saturation value; nonsensical values below 1 behave like 1.
    function automatic logic [CNT_W-1:0] timeout_last(input int timeout);
        if (timeout < 1) begin
            return '0;
        end else if (timeout > (1 << CNT_W)) begin
            return '1;
        end else begin
            return CNT_W'(timeout - 1);
        end
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin picker.
//   valid[1:0] : request lines, bit N is requester N
//   last       : requester granted most recently
//   gnt[1:0]   : one-hot grant (all zero when nobody requests)
// On contention the requester that was not granted last wins.
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves it unassigned would infer a latch.
        gnt = 2'b00;
        if (valid == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = valid;
        end
    end

endmodule

// File: rtl/mem_read_arb.sv
// -----------------------------------------------------------------------------
// mem_read_arb
// Arbitrates read requests from two requesters onto a single memory read port
// with at most one read outstanding.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   reqN_valid / reqN_addr      : read request from requester N, held until ack
//   reqN_ack                    : one-cycle pulse when request N is issued
//   respN_valid / respN_data    : one-cycle response pulse, data held until the
//                                 next response to the same requester
//   mem_readEnable / mem_raddr  : read strobe and address to the memory
//   mem_ready / mem_rdata       : data-valid pulse and data from the memory
//   busy                        : FSM is not IDLE
//   err_timeout                 : sticky, set when a read is abandoned
// -----------------------------------------------------------------------------
module mem_read_arb
    import mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ack,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_data,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ack,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_data,
    output logic              mem_readEnable,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err_timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = timeout_last(TIMEOUT);

    state_e            state;
    state_e            state_next;
    logic [1:0]        gnt;
    logic              win_id;
    logic              last_gnt;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt;
    logic              arb_take;
    logic              wait_done;
    logic              wait_expire;
    logic [DATA_W-1:0] resp_d;

    rr_arb2 u_arb (
        .valid ({req1_valid, req0_valid}),
        .last  (last_gnt),
        .gnt   (gnt)
    );

    // addr_q only changes on the way into ISSUE, so outside ISSUE it is the
    // last issued address.
    assign mem_raddr = addr_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and Moore outputs.
    always_comb begin
        state_next     = state;
        mem_readEnable = 1'b0;
        req0_ack       = 1'b0;
        req1_ack       = 1'b0;
        resp0_valid    = 1'b0;
        resp1_valid    = 1'b0;
        busy           = (state != IDLE);
        arb_take       = 1'b0;
        wait_done      = 1'b0;
        wait_expire    = 1'b0;
        resp_d         = '0;

        case (state)
            IDLE: begin
                if (gnt != 2'b00) begin
                    arb_take   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_readEnable = 1'b1;
                req0_ack       = ~win_id;
                req1_ack       = win_id;
                state_next     = WAIT;
            end
            WAIT: begin
                if (mem_ready) begin
                    wait_done  = 1'b1;
                    resp_d     = mem_rdata;
                    state_next = RESP;
                end else if (cnt >= CNT_LAST) begin
                    // resp_d stays all-zero for an abandoned read
                    wait_expire = 1'b1;
                    state_next  = RESP;
                end
            end
            RESP: begin
                resp0_valid = ~win_id;
                resp1_valid = win_id;
                if (gnt != 2'b00) begin
                    arb_take   = 1'b1;
                    state_next = ISSUE;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: winner, address, WAIT counter, response data, error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_id      <= 1'b0;
            last_gnt    <= 1'b1;
            addr_q      <= '0;
            cnt         <= '0;
            err_timeout <= 1'b0;
            // NOTE: the response data registers are plain flops, not a RAM, so
            // resetting them is cheap and gives defined data after reset.
            resp0_data  <= '0;
            resp1_data  <= '0;
        end else begin
            if (arb_take) begin
                win_id   <= gnt[1];
                last_gnt <= gnt[1];
                addr_q   <= gnt[1] ? req1_addr : req0_addr;
            end

            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT && cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (wait_expire) begin
                err_timeout <= 1'b1;
            end

            if (wait_done || wait_expire) begin
                if (win_id) begin
                    resp1_data <= resp_d;
                end else begin
                    resp0_data <= resp_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_read_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_read_arb
// Self-checking bench for mem_read_arb. A memory model answers each read 100
// edges after it samples mem_readEnable (or never, when disabled). Every ack
// pushes the expected response (requester, data, cycle) to a scoreboard that
// is popped when a response pulse appears.
// -----------------------------------------------------------------------------
module tb_mem_read_arb;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 200;

    typedef struct {
        bit          id;
        logic [15:0] data;
        int          due;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic          req0_ack;
    logic          resp0_valid;
    logic [DW-1:0] resp0_data;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic          req1_ack;
    logic          resp1_valid;
    logic [DW-1:0] resp1_data;
    logic          mem_readEnable;
    logic [AW-1:0] mem_raddr;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          err_timeout;

    int checks = 0;
    int errors = 0;

    int   cyc = 0;
    bit   mem_en = 1'b1;
    bit   force_ready = 1'b0;
    bit   mem_pending = 1'b0;
    int   ready_at = 0;
    logic [AW-1:0] lat_addr = '0;

    exp_t sb[$];
    bit   grant_log[$];
    bit   b2b_log[$];
    int   ack_count = 0;
    int   last_ack_cyc = 0;
    int   resp_count = 0;
    int   busy_cycles = 0;
    logic prev_resp = 1'b0;

    mem_read_arb #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0_valid     (req0_valid),
        .req0_addr      (req0_addr),
        .req0_ack       (req0_ack),
        .resp0_valid    (resp0_valid),
        .resp0_data     (resp0_data),
        .req1_valid     (req1_valid),
        .req1_addr      (req1_addr),
        .req1_ack       (req1_ack),
        .resp1_valid    (resp1_valid),
        .resp1_data     (resp1_data),
        .mem_readEnable (mem_readEnable),
        .mem_raddr      (mem_raddr),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .busy           (busy),
        .err_timeout    (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return (a * 16'd3) ^ 16'h5A5A;
    endfunction

    // Memory model and monitor, evaluated mid-cycle.
    always @(negedge clk) begin
        exp_t        e;
        bit          id;
        logic [15:0] got;

        // Memory model.
        mem_ready = force_ready || (mem_pending && cyc == ready_at);
        if (force_ready) begin
            mem_rdata = 16'hDEAD;
        end else if (mem_pending && cyc == ready_at) begin
            mem_rdata   = memf(lat_addr);
            mem_pending = 1'b0;
        end else begin
            mem_rdata = 16'h5555;
        end

        if (mem_readEnable === 1'b1) begin
            checks++;
            if (mem_pending) begin
                errors++;
                $display("FAIL outstanding: read issued at cycle %0d while another is pending", cyc);
            end
            checks++;
            if ((req0_ack | req1_ack) !== 1'b1) begin
                errors++;
                $display("FAIL strobe_ack: readEnable without ack at cycle %0d", cyc);
            end
            lat_addr = mem_raddr;
            if (mem_en) begin
                mem_pending = 1'b1;
                ready_at    = cyc + 100;
            end
        end

        if (req0_ack === 1'b1 || req1_ack === 1'b1) begin
            checks++;
            if (req0_ack === 1'b1 && req1_ack === 1'b1) begin
                errors++;
                $display("FAIL ack_onehot: both acks high at cycle %0d", cyc);
            end
            id = (req1_ack === 1'b1);
            checks++;
            if (mem_raddr !== (id ? req1_addr : req0_addr)) begin
                errors++;
                $display("FAIL raddr: got %h want %h", mem_raddr, id ? req1_addr : req0_addr);
            end
            e.id   = id;
            e.data = mem_en ? memf(id ? req1_addr : req0_addr) : 16'h0000;
            e.due  = mem_en ? cyc + 101 : cyc + TO + 1;
            sb.push_back(e);
            grant_log.push_back(id);
            b2b_log.push_back(prev_resp === 1'b1);
            ack_count++;
            last_ack_cyc = cyc;
        end

        if (resp0_valid === 1'b1 || resp1_valid === 1'b1) begin
            resp_count++;
            checks++;
            if (resp0_valid === 1'b1 && resp1_valid === 1'b1) begin
                errors++;
                $display("FAIL resp_onehot: both resp valids high at cycle %0d", cyc);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp: resp at cycle %0d with nothing expected", cyc);
            end else begin
                e   = sb.pop_front();
                id  = (resp1_valid === 1'b1);
                got = id ? resp1_data : resp0_data;
                checks++;
                if (id !== e.id) begin
                    errors++;
                    $display("FAIL resp_id: got %0d want %0d", id, e.id);
                end
                checks++;
                if (got !== e.data) begin
                    errors++;
                    $display("FAIL resp_data: got %h want %h", got, e.data);
                end
                checks++;
                if (cyc != e.due) begin
                    errors++;
                    $display("FAIL resp_cycle: got %0d want %0d", cyc, e.due);
                end
            end
        end

        prev_resp = resp0_valid | resp1_valid;
        if (busy === 1'b1) busy_cycles++;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_acks(input int target, input string name);
        int n;
        n = 0;
        while (ack_count < target && n < 2000) begin
            tick(1);
            n++;
        end
        checks++;
        if (ack_count < target) begin
            errors++;
            $display("FAIL %s: acks got %0d want %0d", name, ack_count, target);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 2000) begin
            tick(1);
            n++;
        end
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL %s: %0d responses still expected", name, sb.size());
        end
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_addr  = '0;
        req1_addr  = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
        tick(2);
        checks++;
        if ({busy, err_timeout, mem_readEnable, req0_ack, req1_ack, resp0_valid, resp1_valid} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {busy, err_timeout, mem_readEnable, req0_ack, req1_ack, resp0_valid, resp1_valid});
        end
        checks++;
        if ({mem_raddr, resp0_data, resp1_data} !== 48'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {mem_raddr, resp0_data, resp1_data});
        end
        rst_n = 1'b1;
        tick(2);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_single_read;
        int drive_cyc;
        mem_en     = 1'b1;
        req0_addr  = 16'h0010;
        req0_valid = 1'b1;
        drive_cyc  = cyc;
        wait_acks(ack_count + 1, "single_ack");
        req0_valid = 1'b0;
        checks++;
        if (last_ack_cyc != drive_cyc + 1) begin
            errors++;
            $display("FAIL ack_latency: got cycle %0d want %0d", last_ack_cyc, drive_cyc + 1);
        end
        wait_drain("single_resp");
        tick(2);
        checks++;
        if (resp0_data !== memf(16'h0010)) begin
            errors++;
            $display("FAIL resp0_hold: got %h want %h", resp0_data, memf(16'h0010));
        end
        checks++;
        if (mem_raddr !== 16'h0010) begin
            errors++;
            $display("FAIL raddr_hold: got %h want 0010", mem_raddr);
        end
    endtask

    task automatic test_back_to_back;
        int base;
        bit exp_order[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        rst_n      = 1'b0;
        sb.delete();
        req0_addr  = 16'h0123;
        req1_addr  = 16'h0456;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        base       = ack_count;
        tick(1);
        rst_n = 1'b1;
        wait_acks(base + 4, "b2b_acks");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_drain("b2b_resp");
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (grant_log.size() <= base + i || grant_log[base + i] !== exp_order[i]) begin
                errors++;
                $display("FAIL grant_order[%0d]: got %0d want %0d", i,
                         (grant_log.size() > base + i) ? int'(grant_log[base + i]) : -1, exp_order[i]);
            end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (b2b_log.size() <= base + i || b2b_log[base + i] !== 1'b1) begin
                errors++;
                $display("FAIL issue_after_resp[%0d]: got 0 want 1", i);
            end
        end
        tick(2);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy got %b want 0", busy);
        end
    endtask

    task automatic test_timeout;
        checks++;
        if (resp0_data !== memf(16'h0123) || resp1_data !== memf(16'h0456)) begin
            errors++;
            $display("FAIL hold_pre: got %h/%h want %h/%h", resp0_data, resp1_data,
                     memf(16'h0123), memf(16'h0456));
        end
        mem_en     = 1'b0;
        req1_addr  = 16'h0777;
        req1_valid = 1'b1;
        wait_acks(ack_count + 1, "to_ack");
        req1_valid = 1'b0;
        wait_drain("to_resp");
        mem_en = 1'b1;
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL err_set: got %b want 1", err_timeout);
        end
        req0_addr  = 16'h0BEE;
        req0_valid = 1'b1;
        wait_acks(ack_count + 1, "after_to_ack");
        req0_valid = 1'b0;
        wait_drain("after_to_resp");
        tick(2);
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b want 1", err_timeout);
        end
        checks++;
        if (resp1_data !== 16'h0000 || resp0_data !== memf(16'h0BEE)) begin
            errors++;
            $display("FAIL hold_post: got %h/%h want %h/0000", resp0_data, resp1_data, memf(16'h0BEE));
        end
    endtask

    task automatic test_reset_in_wait;
        int resp_before;
        req0_addr  = 16'h0200;
        req0_valid = 1'b1;
        wait_acks(ack_count + 1, "rw_ack");
        req0_valid = 1'b0;
        tick(10);
        rst_n = 1'b0;
        #1;
        sb.delete();
        checks++;
        if ({busy, err_timeout, mem_readEnable, resp0_valid, resp1_valid} !== 5'b0) begin
            errors++;
            $display("FAIL rw_ctrl: got %b want 00000",
                     {busy, err_timeout, mem_readEnable, resp0_valid, resp1_valid});
        end
        checks++;
        if ({mem_raddr, resp0_data, resp1_data} !== 48'h0) begin
            errors++;
            $display("FAIL rw_data: got %h want 0", {mem_raddr, resp0_data, resp1_data});
        end
        resp_before = resp_count;
        tick(2);
        rst_n = 1'b1;
        tick(120);
        checks++;
        if (resp_count != resp_before || busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_ready: resps got %0d want 0, busy %b", resp_count - resp_before, busy);
        end
    endtask

    task automatic test_ready_in_idle;
        int resp_before;
        int busy_before;
        resp_before = resp_count;
        force_ready = 1'b1;
        tick(1);
        force_ready = 1'b0;
        tick(5);
        checks++;
        if (resp_count != resp_before || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: resps got %0d want 0, busy %b", resp_count - resp_before, busy);
        end
        busy_before = busy_cycles;
        req1_addr   = 16'h0300;
        req1_valid  = 1'b1;
        wait_acks(ack_count + 1, "busy_ack");
        req1_valid = 1'b0;
        wait_drain("busy_resp");
        tick(3);
        checks++;
        if (busy_cycles - busy_before != 102) begin
            errors++;
            $display("FAIL busy_span: got %0d want 102", busy_cycles - busy_before);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_timeout();
        test_reset_in_wait();
        test_ready_in_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
